// File: rtl/jstk_multi_axis_stepper.sv
// rtl/jstk_multi_axis_stepper.sv - N-axis joystick-to-stepper driver with deadzone, 4-level speed and signed position
module jstk_multi_axis_stepper #(
    parameter int NUM_AXES = 2,
    parameter int DATA_W   = 10,
    parameter int CENTER   = 512,
    parameter int DEADZONE = 40,
    parameter int BASE_DIV = 16,
    parameter int POS_W    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_AXES*DATA_W-1:0]   axis_data,
    input  logic                         axis_valid,
    input  logic [NUM_AXES-1:0]          en,
    input  logic                         half_step,
    output logic [NUM_AXES*4-1:0]        coil,
    output logic [NUM_AXES-1:0]          step_pulse,
    output logic [NUM_AXES-1:0]          step_dir,
    output logic [NUM_AXES*POS_W-1:0]    position
);

    localparam int PER_W = $clog2(BASE_DIV + 1);
    localparam logic [DATA_W-1:0] CENTER_V = DATA_W'(CENTER);
    localparam logic [DATA_W-1:0] DZ_V     = DATA_W'(DEADZONE);
    localparam logic [PER_W-1:0]  BASE_V   = PER_W'(BASE_DIV);

    typedef enum logic [1:0] {
        AXIS_DISABLED,
        AXIS_IDLE,
        AXIS_RUN
    } axis_mode_t;

    function automatic logic [3:0] phase_coil(input logic [2:0] p);
        case (p)
            3'd0:    return 4'b1000;
            3'd1:    return 4'b1100;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b0110;
            3'd4:    return 4'b0010;
            3'd5:    return 4'b0011;
            3'd6:    return 4'b0001;
            default: return 4'b1001;
        endcase
    endfunction

    // Full-step always lands on an even phase, so an odd phase snaps to its neighbour.
    function automatic logic [2:0] next_phase(input logic [2:0] p, input logic fwd,
                                              input logic half);
        if (half)
            return fwd ? p + 3'd1 : p - 3'd1;
        else if (fwd)
            return (p + 3'd2) & 3'b110;
        else
            return (p - 3'd1) & 3'b110;
    endfunction

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        logic [DATA_W-1:0] sample_q;
        logic [2:0]        phase_q;
        logic [3:0]        coil_q;
        logic [PER_W-1:0]  cnt_q;
        logic              pulse_q;
        logic              dir_q;
        logic [POS_W-1:0]  pos_q;

        logic [DATA_W-1:0] mag;
        logic [DATA_W-1:0] excess;
        logic [DATA_W-1:0] lvl_raw;
        logic [1:0]        level;
        logic [PER_W-1:0]  period;
        logic              fwd;
        axis_mode_t        mode;

        always_comb begin
            fwd     = sample_q > CENTER_V;
            mag     = fwd ? sample_q - CENTER_V : CENTER_V - sample_q;
            excess  = mag - DZ_V;
            lvl_raw = excess >> (DATA_W - 3);
            level   = (lvl_raw > DATA_W'(3)) ? 2'd3 : lvl_raw[1:0];
            period  = BASE_V >> level;
            if (!en[i])
                mode = AXIS_DISABLED;
            else if (mag <= DZ_V)
                mode = AXIS_IDLE;
            else
                mode = AXIS_RUN;
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                sample_q <= CENTER_V;
                phase_q  <= 3'd0;
                coil_q   <= 4'd0;
                cnt_q    <= '0;
                pulse_q  <= 1'b0;
                dir_q    <= 1'b0;
                pos_q    <= '0;
            end else begin
                pulse_q <= 1'b0;
                if (axis_valid)
                    sample_q <= axis_data[i*DATA_W +: DATA_W];
                case (mode)
                    AXIS_DISABLED: begin
                        coil_q <= 4'd0;
                        cnt_q  <= '0;
                    end
                    AXIS_IDLE: begin
                        coil_q <= phase_coil(phase_q);
                        cnt_q  <= '0;
                    end
                    default: begin
                        // >= rather than == so a shortened period fires immediately
                        if (cnt_q >= period - PER_W'(1)) begin
                            cnt_q   <= '0;
                            phase_q <= next_phase(phase_q, fwd, half_step);
                            coil_q  <= phase_coil(next_phase(phase_q, fwd, half_step));
                            pos_q   <= fwd ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
                            pulse_q <= 1'b1;
                            dir_q   <= fwd;
                        end else begin
                            cnt_q <= cnt_q + PER_W'(1);
                        end
                    end
                endcase
            end
        end

        assign coil[i*4 +: 4]           = coil_q;
        assign step_pulse[i]            = pulse_q;
        assign step_dir[i]              = dir_q;
        assign position[i*POS_W +: POS_W] = pos_q;
    end

endmodule

// File: tb/tb_jstk_multi_axis_stepper.sv
// tb/tb_jstk_multi_axis_stepper.sv - directed and randomized bench for jstk_multi_axis_stepper
module tb_jstk_multi_axis_stepper;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] axis_data;
    logic        axis_valid;
    logic [1:0]  en;
    logic        half_step;
    logic [7:0]  coil;
    logic [1:0]  step_pulse;
    logic [1:0]  step_dir;
    logic [31:0] position;

    always #5 clk = ~clk;

    jstk_multi_axis_stepper #(
        .NUM_AXES(2), .DATA_W(10), .CENTER(512), .DEADZONE(40), .BASE_DIV(16), .POS_W(16)
    ) dut (
        .clk(clk), .rst(rst), .axis_data(axis_data), .axis_valid(axis_valid), .en(en),
        .half_step(half_step), .coil(coil), .step_pulse(step_pulse), .step_dir(step_dir),
        .position(position)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [3:0]  coil_tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                                  4'b0010, 4'b0011, 4'b0001, 4'b1001};
    int          m_samp  [2];
    int          m_ph    [2];
    int          m_since [2];
    logic [15:0] m_pos   [2];
    logic [3:0]  m_coil  [2];
    logic        m_pulse [2];
    logic        m_dir   [2];

    function automatic int next_ph(input int p, input bit fwd, input bit half);
        if (half) return fwd ? (p + 1) % 8 : (p + 7) % 8;
        if (fwd) return ((p / 2) * 2 + 2) % 8;
        return (p % 2 == 1) ? p - 1 : (p + 6) % 8;
    endfunction

    task automatic model_update();
        for (int a = 0; a < 2; a++) begin
            if (!rst) begin
                m_samp[a] = 512; m_ph[a] = 0; m_since[a] = 0; m_pos[a] = 16'd0;
                m_coil[a] = 4'd0; m_pulse[a] = 1'b0; m_dir[a] = 1'b0;
            end else begin
                int mag, lvl, per;
                bit fwd;
                fwd = m_samp[a] > 512;
                mag = fwd ? m_samp[a] - 512 : 512 - m_samp[a];
                m_pulse[a] = 1'b0;
                if (!en[a]) begin
                    m_coil[a] = 4'd0; m_since[a] = 0;
                end else if (mag <= 40) begin
                    m_coil[a] = coil_tbl[m_ph[a]]; m_since[a] = 0;
                end else begin
                    lvl = (mag - 40) / 128;
                    if (lvl > 3) lvl = 3;
                    per = 16 / (1 << lvl);
                    if (m_since[a] + 1 >= per) begin
                        m_ph[a]    = next_ph(m_ph[a], fwd, half_step);
                        m_pos[a]   = fwd ? m_pos[a] + 16'd1 : m_pos[a] - 16'd1;
                        m_coil[a]  = coil_tbl[m_ph[a]];
                        m_pulse[a] = 1'b1;
                        m_dir[a]   = fwd;
                        m_since[a] = 0;
                    end else begin
                        m_since[a]++;
                    end
                end
                if (axis_valid) m_samp[a] = int'(axis_data[a*10 +: 10]);
            end
        end
    endtask

    task automatic compare();
        for (int a = 0; a < 2; a++) begin
            check($sformatf("coil%0d", a),  32'(coil[a*4 +: 4]),      32'(m_coil[a]));
            check($sformatf("pulse%0d", a), 32'(step_pulse[a]),       32'(m_pulse[a]));
            check($sformatf("dir%0d", a),   32'(step_dir[a]),         32'(m_dir[a]));
            check($sformatf("pos%0d", a),   32'(position[a*16 +: 16]), 32'(m_pos[a]));
        end
    endtask

    task automatic tick();
        model_update();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic latch(input int d0, input int d1);
        axis_data  = {10'(d1), 10'(d0)};
        axis_valid = 1'b1;
        tick();
        axis_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int a, input string tag);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (!step_pulse[a] && k < 40);
        if (!step_pulse[a]) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    function automatic int pick_sample();
        case ($urandom_range(0, 5))
            0:       return 512;
            1:       return 512 + $urandom_range(0, 90) - 45;
            2:       return 0;
            3:       return 1023;
            default: return $urandom_range(0, 1023);
        endcase
    endfunction

    int          n;
    logic [15:0] p0;
    logic [3:0]  seen [4];
    logic [3:0]  exp_half [4] = '{4'b1001, 4'b0001, 4'b0011, 4'b0010};

    initial begin
        rst = 1'b0; axis_data = {10'd512, 10'd512}; axis_valid = 1'b0;
        en = 2'b11; half_step = 1'b0;
        tick(); tick();
        check("rst_coil", 32'(coil), 32'd0);
        check("rst_pos", position, 32'd0);
        check("rst_pulse", 32'(step_pulse), 32'd0);

        rst = 1'b1;
        latch(512, 512);
        n = 0;
        repeat (20) begin tick(); n += int'(step_pulse[0]) + int'(step_pulse[1]); end
        check("center_steps", n, 0);
        check("idle_hold_coil", 32'(coil), 32'h88);

        latch(552, 512);
        n = 0;
        repeat (40) begin tick(); n += int'(step_pulse[0]); end
        check("dz552_steps", n, 0);
        latch(553, 512);
        n = 0;
        repeat (64) begin tick(); n += int'(step_pulse[0]); end
        check("dz553_steps", n, 4);
        check("dz553_dir", 32'(step_dir[0]), 32'd1);

        p0 = position[15:0];
        latch(1000, 512);
        repeat (100) tick();
        check("speed3_delta", 32'(16'(position[15:0] - p0)), 32'd50);

        half_step = 1'b1;
        latch(1000, 0);
        n = 0;
        for (int k = 0; k < 40 && n < 4; k++) begin
            tick();
            if (step_pulse[1]) begin seen[n] = coil[7:4]; n++; end
        end
        check("half_cnt", n, 4);
        for (int k = 0; k < 4; k++) check($sformatf("half_coil%0d", k), 32'(seen[k]), 32'(exp_half[k]));
        check("half_pos", 32'(position[31:16]), 32'h0000fffc);

        rst = 1'b0; tick(); tick(); rst = 1'b1;
        en = 2'b01; half_step = 1'b1;
        latch(1000, 512);
        wait_pulse(0, "odd_first");
        check("odd_ph1_coil", 32'(coil[3:0]), 32'b1100);
        half_step = 1'b0;
        wait_pulse(0, "odd_second");
        check("odd_ph2_coil", 32'(coil[3:0]), 32'b0100);
        wait_pulse(0, "odd_third");
        check("odd_ph4_coil", 32'(coil[3:0]), 32'b0010);

        en = 2'b00;
        tick();
        check("dis_coil", 32'(coil[3:0]), 32'd0);
        p0 = position[15:0];
        n = 0;
        repeat (10) begin tick(); n += int'(step_pulse[0]); end
        check("dis_steps", n, 0);
        check("dis_pos", 32'(position[15:0]), 32'(p0));
        en = 2'b11;
        repeat (7) tick();
        rst = 1'b0;
        tick();
        check("midrst_coil", 32'(coil), 32'd0);
        check("midrst_pos", position, 32'd0);
        check("midrst_pulse", 32'(step_pulse), 32'd0);
        check("midrst_dir", 32'(step_dir), 32'd0);
        rst = 1'b1;

        repeat (3000) begin
            if ($urandom_range(0, 7) == 0) begin
                axis_data[9:0]   = 10'(pick_sample());
                axis_data[19:10] = 10'(pick_sample());
                axis_valid = 1'b1;
            end else begin
                axis_valid = 1'b0;
            end
            if ($urandom_range(0, 31) == 0) en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 63) == 0) half_step = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 499) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
